goldschmidt_rsqrt_pipe: RTL and testbench

Parametrised, fully pipelined Goldschmidt square-root / reciprocal-square-root unit for signed fixed-point (`sfp_if`) operands. It takes an operand S and a seed estimate y0 ≈ 1/√S and runs ITERS refinement iterations. It returns 1/√S and √S together with a caller tag and status flags. It sits in the ray-tracer datapath behind the seed lookup, feeding vector normalisation. A valid/ready handshake with full back-pressure stalls the whole pipeline.

---
 rtl/goldschmidt_rsqrt_pipe.sv | 171 +++++++++++++++++
 tb/tb_goldschmidt_rsqrt_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/goldschmidt_rsqrt_pipe.sv
// Pipelined Goldschmidt 1/sqrt(S) and sqrt(S) on signed IW.QW fixed point.
// One accept stage, three stages per iteration, then a registered output; a single advance stalls everything.
module goldschmidt_rsqrt_pipe #(
  parameter int IW    = 12,
  parameter int QW    = 20,
  parameter int ITERS = 2,
  parameter int TAGW  = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IW+QW-1:0]    in,
  input  logic [IW+QW-1:0]    est,
  input  logic [TAGW-1:0]     in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IW+QW-1:0]    rsqrt,
  output logic [IW+QW-1:0]    sqrt,
  output logic [TAGW-1:0]     out_tag,
  output logic                out_sat,
  output logic                out_err
);

  localparam int W  = IW + QW;
  localparam int NS = 1 + 3 * ITERS;
  localparam int PW = 2 * W;

  localparam logic [W-1:0] MAXV  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] THREE = {{(IW-2){1'b0}}, 2'b11, {QW{1'b0}}};

  // Returns {saturated, value}: product floored to QW fraction bits, clamped to W bits.
  function automatic logic [W:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;
    logic signed [PW-1:0] p;
    logic [IW:0]          hi;
    ae = {{W{a[W-1]}}, a};
    be = {{W{b[W-1]}}, b};
    p  = ae * be;
    hi = p[PW-1:W+QW-1];
    if (hi == '0 || hi == '1) begin
      return {1'b0, p[W+QW-1:QW]};
    end else if (p[PW-1]) begin
      return {1'b1, MINV};
    end else begin
      return {1'b1, MAXV};
    end
  endfunction

  // Returns {saturated, (3 - b) >>> 1}; the subtract saturates before the halving.
  function automatic logic [W:0] fx_half3(input logic [W-1:0] b);
    logic [W:0]   d;
    logic [W-1:0] s;
    logic         ovf;
    d   = {THREE[W-1], THREE} - {b[W-1], b};
    ovf = d[W] ^ d[W-1];
    s   = ovf ? (d[W] ? MINV : MAXV) : d[W-1:0];
    return {ovf, s[W-1], s[W-1:1]};
  endfunction

  logic                 adv;
  logic [NS-1:0]        v_q, v_d;
  logic [NS-1:0]        sat_q, sat_d;
  logic [NS-1:0]        err_q, err_d;
  logic [NS-1:0][W-1:0] x_q, x_d;
  logic [NS-1:0][W-1:0] y_q, y_d;
  logic [NS-1:0][W-1:0] rr_q, rr_d;
  logic [NS-1:0][W-1:0] b_q, b_d;
  logic [NS-1:0][W-1:0] g_q, g_d;
  logic [NS-1:0][TAGW-1:0] tag_q, tag_d;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage k >= 1 sees stage k-1; (k-1) % 3 selects P1 (b*rr), P2 (halved 3-b) or P3 (x, y, rr update).
  always_comb begin
    logic [W:0] m0;
    logic [W:0] m1;
    logic [W:0] m2;
    m0 = fx_mul(in, est);
    m1 = fx_mul(est, est);
    m2 = '0;
    v_d[0]   = in_valid;
    x_d[0]   = m0[W-1:0];
    rr_d[0]  = m1[W-1:0];
    y_d[0]   = est;
    b_d[0]   = in;
    g_d[0]   = '0;
    tag_d[0] = in_tag;
    err_d[0] = in[W-1] || (in == '0);
    sat_d[0] = m0[W] | m1[W];
    for (int k = 1; k < NS; k++) begin
      v_d[k]   = v_q[k-1];
      x_d[k]   = x_q[k-1];
      y_d[k]   = y_q[k-1];
      rr_d[k]  = rr_q[k-1];
      b_d[k]   = b_q[k-1];
      g_d[k]   = g_q[k-1];
      tag_d[k] = tag_q[k-1];
      err_d[k] = err_q[k-1];
      sat_d[k] = sat_q[k-1];
      case ((k - 1) % 3)
        0: begin
          m0       = fx_mul(b_q[k-1], rr_q[k-1]);
          b_d[k]   = m0[W-1:0];
          sat_d[k] = sat_q[k-1] | m0[W];
        end
        1: begin
          m0       = fx_half3(b_q[k-1]);
          g_d[k]   = m0[W-1:0];
          sat_d[k] = sat_q[k-1] | m0[W];
        end
        default: begin
          m0       = fx_mul(x_q[k-1], g_q[k-1]);
          m1       = fx_mul(y_q[k-1], g_q[k-1]);
          m2       = fx_mul(g_q[k-1], g_q[k-1]);
          x_d[k]   = m0[W-1:0];
          y_d[k]   = m1[W-1:0];
          rr_d[k]  = m2[W-1:0];
          sat_d[k] = sat_q[k-1] | m0[W] | m1[W] | m2[W];
        end
      endcase
    end
  end

  // Data registers only load behind a valid sample so held results never pick up bubble contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_q       <= '0;
      sat_q     <= '0;
      err_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      rr_q      <= '0;
      b_q       <= '0;
      g_q       <= '0;
      tag_q     <= '0;
      out_valid <= 1'b0;
      rsqrt     <= '0;
      sqrt      <= '0;
      out_tag   <= '0;
      out_sat   <= 1'b0;
      out_err   <= 1'b0;
    end else if (adv) begin
      v_q <= v_d;
      for (int k = 0; k < NS; k++) begin
        if (v_d[k]) begin
          x_q[k]   <= x_d[k];
          y_q[k]   <= y_d[k];
          rr_q[k]  <= rr_d[k];
          b_q[k]   <= b_d[k];
          g_q[k]   <= g_d[k];
          tag_q[k] <= tag_d[k];
          err_q[k] <= err_d[k];
          sat_q[k] <= sat_d[k];
        end
      end
      out_valid <= v_q[NS-1];
      if (v_q[NS-1]) begin
        rsqrt   <= err_q[NS-1] ? '0 : y_q[NS-1];
        sqrt    <= err_q[NS-1] ? '0 : x_q[NS-1];
        out_tag <= tag_q[NS-1];
        out_sat <= sat_q[NS-1] & ~err_q[NS-1];
        out_err <= err_q[NS-1];
      end
    end
  end

endmodule

// File: tb/tb_goldschmidt_rsqrt_pipe.sv
// Directed bench for goldschmidt_rsqrt_pipe: ITERS=2 main instance plus an ITERS=1 instance on the same inputs.
module tb_goldschmidt_rsqrt_pipe;

  localparam int IW   = 12;
  localparam int QW   = 20;
  localparam int TAGW = 4;
  localparam int W    = IW + QW;

  localparam logic [W-1:0] FX_4    = 32'h0040_0000;
  localparam logic [W-1:0] FX_2    = 32'h0020_0000;
  localparam logic [W-1:0] FX_HALF = 32'h0008_0000;
  localparam logic [W-1:0] FX_0P7  = 32'd734003;
  localparam logic [W-1:0] FX_M1   = 32'hFFF0_0000;
  localparam logic [W-1:0] FX_1000 = 32'h3E80_0000;
  localparam logic [W-1:0] FX_100  = 32'h0640_0000;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [W-1:0]    s_in = '0;
  logic [W-1:0]    est = '0;
  logic [TAGW-1:0] in_tag = '0;

  logic            in_ready, out_valid, out_sat, out_err;
  logic [W-1:0]    rsqrt, sqrt;
  logic [TAGW-1:0] out_tag;

  logic            in_ready1, out_valid1, out_sat1, out_err1;
  logic [W-1:0]    rsqrt1, sqrt1;
  logic [TAGW-1:0] out_tag1;

  int checks = 0;
  int failures = 0;

  int              lat2, lat1, cnt2;
  logic [W-1:0]    r2, q2, r1, q1;
  logic [TAGW-1:0] tag2;
  logic            sat2, err2;

  goldschmidt_rsqrt_pipe #(.IW(IW), .QW(QW), .ITERS(2), .TAGW(TAGW)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in(s_in), .est(est), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .rsqrt(rsqrt), .sqrt(sqrt), .out_tag(out_tag), .out_sat(out_sat), .out_err(out_err)
  );

  goldschmidt_rsqrt_pipe #(.IW(IW), .QW(QW), .ITERS(1), .TAGW(TAGW)) dut1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready1),
    .in(s_in), .est(est), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready),
    .rsqrt(rsqrt1), .sqrt(sqrt1), .out_tag(out_tag1), .out_sat(out_sat1), .out_err(out_err1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  function automatic int absDiff(input logic [W-1:0] a, input int e);
    int d;
    d = int'($signed(a)) - e;
    return (d < 0) ? -d : d;
  endfunction

  // Single-cycle pulse, then capture the first result of each instance and its latency.
  task automatic applyStimulus(input logic [W-1:0] s, input logic [W-1:0] e, input logic [TAGW-1:0] t);
    in_valid = 1'b1;
    s_in     = s;
    est      = e;
    in_tag   = t;
    stepClock();
    in_valid = 1'b0;
    lat2 = -1;
    lat1 = -1;
    cnt2 = 0;
    for (int n = 1; n <= 25; n++) begin
      stepClock();
      if (out_valid) begin
        cnt2++;
        if (lat2 < 0) begin
          lat2 = n;
          r2   = rsqrt;
          q2   = sqrt;
          tag2 = out_tag;
          sat2 = out_sat;
          err2 = out_err;
        end
      end
      if (out_valid1 && lat1 < 0) begin
        lat1 = n;
        r1   = rsqrt1;
        q1   = sqrt1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (resetn) checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c, next_tag, exp_tag, extra, stale;
    logic prev_stall;
    logic [W-1:0] prev_r;
    logic [TAGW-1:0] prev_t;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_rsqrt", rsqrt, 0);
    checkOutput("rst_sqrt", sqrt, 0);
    checkOutput("rst_tag", out_tag, 0);
    checkOutput("rst_sat", out_sat, 0);
    checkOutput("rst_err", out_err, 0);
    resetn = 1'b1;

    $display("[TB] S=4.0 est=0.5");
    applyStimulus(FX_4, FX_HALF, 4'd3);
    checkOutput("s4_lat", lat2, 7);
    checkOutput("s4_count", cnt2, 1);
    checkOutput("s4_rsqrt", r2, 32'h0008_0000);
    checkOutput("s4_sqrt", q2, 32'h0020_0000);
    checkOutput("s4_tag", tag2, 3);
    checkOutput("s4_sat", sat2, 0);
    checkOutput("s4_err", err2, 0);
    checkOutput("s4_i1_lat", lat1, 4);
    checkOutput("s4_i1_rsqrt", r1, 32'h0008_0000);
    checkOutput("s4_i1_sqrt", q1, 32'h0020_0000);

    $display("[TB] S=2.0 est=0.7");
    applyStimulus(FX_2, FX_0P7, 4'd5);
    checkOutput("s2_lat", lat2, 7);
    checkOutput("s2_rsqrt_tol", absDiff(r2, 741455) <= 16, 1);
    checkOutput("s2_sqrt_tol", absDiff(q2, 1482910) <= 16, 1);
    checkOutput("s2_i1_lat", lat1, 4);
    checkOutput("s2_i1_rsqrt_tol", absDiff(r1, 741343) <= 16, 1);
    checkOutput("s2_i1_sqrt_tol", absDiff(q1, 1482686) <= 16, 1);

    $display("[TB] S<=0 cases");
    applyStimulus('0, FX_HALF, 4'd9);
    checkOutput("z_lat", lat2, 7);
    checkOutput("z_err", err2, 1);
    checkOutput("z_rsqrt", r2, 0);
    checkOutput("z_sqrt", q2, 0);
    checkOutput("z_sat", sat2, 0);
    checkOutput("z_tag", tag2, 9);
    applyStimulus(FX_M1, FX_100, 4'd10);
    checkOutput("neg_lat", lat2, 7);
    checkOutput("neg_err", err2, 1);
    checkOutput("neg_rsqrt", r2, 0);
    checkOutput("neg_sqrt", q2, 0);
    checkOutput("neg_sat", sat2, 0);
    checkOutput("neg_tag", tag2, 10);

    $display("[TB] saturation S=1000 est=100");
    applyStimulus(FX_1000, FX_100, 4'd12);
    checkOutput("sat_flag", sat2, 1);
    checkOutput("sat_err", err2, 0);
    checkOutput("sat_rsqrt", r2, 32'h7FFF_FFFF);
    checkOutput("sat_sqrt", q2, 32'h7FFF_FFFF);
    checkOutput("sat_tag", tag2, 12);
    checkOutput("sat_i1_rsqrt", r1, 32'h8000_0000);
    checkOutput("sat_i1_sqrt", q1, 32'h8000_0000);

    $display("[TB] stream of 16 with back-pressure");
    c = 0;
    next_tag = 0;
    exp_tag = 0;
    prev_stall = 1'b0;
    prev_r = '0;
    prev_t = '0;
    while (exp_tag < 16 && c < 80) begin
      if (prev_stall) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_tag", out_tag, prev_t);
        checkOutput("stall_rsqrt", rsqrt, prev_r);
      end
      out_ready = !(c inside {5, 6, 7, 8, 12});
      in_valid  = (next_tag < 16);
      s_in      = FX_4;
      est       = FX_HALF;
      in_tag    = next_tag[TAGW-1:0];
      #1;
      if (out_valid && out_ready) begin
        checkOutput("stream_tag", out_tag, exp_tag[TAGW-1:0]);
        checkOutput("stream_rsqrt", rsqrt, 32'h0008_0000);
        exp_tag++;
      end
      if (in_valid && in_ready) next_tag++;
      prev_stall = out_valid && !out_ready;
      prev_r = rsqrt;
      prev_t = out_tag;
      stepClock();
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_count", exp_tag, 16);
    extra = 0;
    repeat (10) begin
      stepClock();
      if (out_valid) extra++;
    end
    checkOutput("stream_no_dup", extra, 0);

    $display("[TB] reset mid-flight");
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      s_in     = FX_4;
      est      = FX_HALF;
      in_tag   = i[TAGW-1:0];
      stepClock();
    end
    in_valid = 1'b0;
    for (int n = 0; n < 10 && !out_valid; n++) stepClock();
    checkOutput("pre_reset_valid", out_valid, 1);
    resetn = 1'b0;
    #1;
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_rsqrt", rsqrt, 0);
    checkOutput("mid_rst_sqrt", sqrt, 0);
    checkOutput("mid_rst_tag", out_tag, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1);
    stepClock();
    resetn = 1'b1;
    stale = 0;
    repeat (15) begin
      stepClock();
      if (out_valid) stale++;
    end
    checkOutput("no_stale", stale, 0);
    applyStimulus(FX_4, FX_HALF, 4'd7);
    checkOutput("post_rst_lat", lat2, 7);
    checkOutput("post_rst_tag", tag2, 7);
    checkOutput("post_rst_rsqrt", r2, 32'h0008_0000);
    checkOutput("post_rst_count", cnt2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
